// File: rtl/l2_writeback_buffer_pkg.sv
// Shared line types, FSM state encodings and address helpers for the L2 write-back buffer.
package l2_writeback_buffer_pkg;

    localparam int LINE_OFFSET_BITS = 5;

    typedef logic [255:0] lc3b_c_line;
    typedef logic [10:0]  lc3b_line_tag;

    typedef enum logic [1:0] {
        U_IDLE = 2'd0,
        U_RESP = 2'd1,
        U_FILL = 2'd2
    } up_state_e;

    typedef enum logic {
        D_IDLE  = 1'b0,
        D_WRITE = 1'b1
    } dn_state_e;

    function automatic lc3b_line_tag line_tag(input logic [15:0] addr);
        return addr[15:LINE_OFFSET_BITS];
    endfunction

    function automatic logic [15:0] line_addr(input lc3b_line_tag tag);
        return {tag, {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/l2_writeback_buffer_if.sv
// Line-granular memory port: the L2 side drives it as master, memory answers as slave.
interface l2_writeback_buffer_if;
    import l2_writeback_buffer_pkg::*;

    logic [15:0] address;
    logic        read;
    logic        write;
    lc3b_c_line  wdata;
    lc3b_c_line  rdata;
    logic        resp;

    modport master (output address, output read, output write, output wdata,
                    input  rdata, input resp);
    modport slave  (input  address, input read, input write, input wdata,
                    output rdata, output resp);
endinterface

// File: rtl/l2_writeback_buffer_entry_array.sv
// Circular queue of buffered lines with tag lookup; at most one valid entry per line tag.
module l2_wb_entry_array
    import l2_writeback_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_enq,
    input  lc3b_line_tag    i_enq_tag,
    input  lc3b_c_line      i_enq_data,
    input  logic            i_coal,
    input  logic [IW-1:0]   i_coal_idx,
    input  lc3b_c_line      i_coal_data,
    input  logic            i_deq,
    input  lc3b_line_tag    i_lookup_tag,
    output logic            o_match,
    output logic [IW-1:0]   o_match_idx,
    output lc3b_c_line      o_match_data,
    output logic [IW-1:0]   o_head_idx,
    output lc3b_line_tag    o_head_tag,
    output lc3b_c_line      o_head_data,
    output logic [CW-1:0]   o_count
);
    logic [IW-1:0]  r_head;
    logic [IW-1:0]  r_tail;
    logic [CW-1:0]  r_count;
    logic [DEPTH-1:0] w_match_vec;
    lc3b_line_tag   w_tag_arr  [DEPTH];
    lc3b_c_line     w_data_arr [DEPTH];

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic         r_valid;
        lc3b_line_tag r_tag;
        lc3b_c_line   r_data;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_tag   <= '0;
            end else if (i_enq && r_tail == IW'(gi)) begin
                r_valid <= 1'b1;
                r_tag   <= i_enq_tag;
            end else if (i_deq && r_head == IW'(gi)) begin
                r_valid <= 1'b0;
            end
        end

        // Line data is meaningless while the entry is invalid, so it carries no reset.
        always_ff @(posedge clk) begin
            if (i_enq && r_tail == IW'(gi)) begin
                r_data <= i_enq_data;
            end else if (i_coal && i_coal_idx == IW'(gi)) begin
                r_data <= i_coal_data;
            end
        end

        assign w_match_vec[gi] = r_valid && (r_tag == i_lookup_tag);
        assign w_tag_arr[gi]   = r_tag;
        assign w_data_arr[gi]  = r_data;
    end

    always_comb begin
        o_match_data = '0;
        o_match_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_match_vec[i]) begin
                o_match_data = w_data_arr[i];
                o_match_idx  = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_enq) r_tail <= ptr_inc(r_tail);
            if (i_deq) r_head <= ptr_inc(r_head);
            case ({i_enq, i_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_match     = |w_match_vec;
    assign o_head_idx  = r_head;
    assign o_head_tag  = w_tag_arr[r_head];
    assign o_head_data = w_data_arr[r_head];
    assign o_count     = r_count;

endmodule

// File: rtl/l2_writeback_buffer.sv
// Write-back buffer between L2 and physical memory: fast eviction acks, background drains,
// buffered read hits, and read misses that take priority over drains.
module l2_writeback_buffer
    import l2_writeback_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    l2_writeback_buffer_if.slave  up,
    l2_writeback_buffer_if.master pmem
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    up_state_e     r_ustate;
    dn_state_e     r_dstate;
    logic          r_up_resp;
    logic          r_pmem_read;
    logic          r_pmem_write;
    lc3b_c_line    r_up_rdata;

    lc3b_line_tag  w_tag;
    lc3b_line_tag  w_head_tag;
    lc3b_c_line    w_match_data;
    lc3b_c_line    w_head_data;
    logic          w_match;
    logic [IW-1:0] w_match_idx;
    logic [IW-1:0] w_head_idx;
    logic [CW-1:0] w_count;
    logic          w_u_idle;
    logic          w_match_draining;
    logic          w_coal;
    logic          w_enq;
    logic          w_hit;
    logic          w_fill_start;
    logic          w_drain_start;
    logic          w_deq;

    assign w_tag    = line_tag(up.address);
    assign w_u_idle = (r_ustate == U_IDLE);

    // The head entry is write-protected only once its drain is actually on the bus.
    assign w_match_draining = w_match && (r_dstate == D_WRITE) && (w_match_idx == w_head_idx);
    assign w_coal        = w_u_idle && up.write && w_match && !w_match_draining;
    assign w_enq         = w_u_idle && up.write && !w_match && (w_count < CW'(DEPTH));
    assign w_hit         = w_u_idle && up.read && w_match;
    assign w_fill_start  = w_u_idle && up.read && !w_match && (r_dstate == D_IDLE);
    assign w_drain_start = (r_dstate == D_IDLE) && (w_count != '0)
                           && (r_ustate != U_FILL) && !w_fill_start;
    assign w_deq         = (r_dstate == D_WRITE) && pmem.resp;

    l2_wb_entry_array #(.DEPTH(DEPTH)) u_array (
        .clk          (clk),
        .reset        (reset),
        .i_enq        (w_enq),
        .i_enq_tag    (w_tag),
        .i_enq_data   (up.wdata),
        .i_coal       (w_coal),
        .i_coal_idx   (w_match_idx),
        .i_coal_data  (up.wdata),
        .i_deq        (w_deq),
        .i_lookup_tag (w_tag),
        .o_match      (w_match),
        .o_match_idx  (w_match_idx),
        .o_match_data (w_match_data),
        .o_head_idx   (w_head_idx),
        .o_head_tag   (w_head_tag),
        .o_head_data  (w_head_data),
        .o_count      (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ustate    <= U_IDLE;
            r_up_resp   <= 1'b0;
            r_pmem_read <= 1'b0;
            r_up_rdata  <= '0;
        end else begin
            r_up_resp <= 1'b0;
            case (r_ustate)
                U_IDLE: begin
                    if (w_coal || w_enq) begin
                        r_ustate  <= U_RESP;
                        r_up_resp <= 1'b1;
                    end else if (w_hit) begin
                        r_up_rdata <= w_match_data;
                        r_ustate   <= U_RESP;
                        r_up_resp  <= 1'b1;
                    end else if (w_fill_start) begin
                        r_ustate    <= U_FILL;
                        r_pmem_read <= 1'b1;
                    end
                end
                U_FILL: begin
                    if (pmem.resp) begin
                        r_up_rdata  <= pmem.rdata;
                        r_pmem_read <= 1'b0;
                        r_ustate    <= U_RESP;
                        r_up_resp   <= 1'b1;
                    end
                end
                U_RESP:  r_ustate <= U_IDLE;
                default: r_ustate <= U_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dstate     <= D_IDLE;
            r_pmem_write <= 1'b0;
        end else begin
            case (r_dstate)
                D_IDLE: begin
                    if (w_drain_start) begin
                        r_dstate     <= D_WRITE;
                        r_pmem_write <= 1'b1;
                    end
                end
                D_WRITE: begin
                    if (pmem.resp) begin
                        r_dstate     <= D_IDLE;
                        r_pmem_write <= 1'b0;
                    end
                end
                default: r_dstate <= D_IDLE;
            endcase
        end
    end

    // Drain address/data come straight from the protected head entry, so they hold stable.
    assign pmem.read    = r_pmem_read;
    assign pmem.write   = r_pmem_write;
    assign pmem.address = r_pmem_read  ? line_addr(w_tag) :
                          r_pmem_write ? line_addr(w_head_tag) : 16'h0000;
    assign pmem.wdata   = r_pmem_write ? w_head_data : '0;
    assign up.rdata     = r_up_rdata;
    assign up.resp      = r_up_resp;

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Directed bench for l2_writeback_buffer: evictions, buffer hits, full stall, coalescing,
// read-miss priority and asynchronous reset, with a logged pmem model.
module tb_l2_writeback_buffer;
    import l2_writeback_buffer_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        lc3b_c_line  data;
    } op_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   auto_en = 1'b0;
    int   auto_cnt = 0;
    op_t  ops[$];
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;

    l2_writeback_buffer_if up_if ();
    l2_writeback_buffer_if pm_if ();

    l2_writeback_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .up    (up_if),
        .pmem  (pm_if)
    );

    always #5 clk = ~clk;

    function automatic lc3b_c_line mk(input logic [31:0] s);
        return {8{s}};
    endfunction

    // Log each new pmem transaction in issue order.
    always @(negedge clk) begin
        if (pm_if.read && !prev_rd)  ops.push_back(op_t'{1'b0, pm_if.address, '0});
        if (pm_if.write && !prev_wr) ops.push_back(op_t'{1'b1, pm_if.address, pm_if.wdata});
        prev_rd = pm_if.read;
        prev_wr = pm_if.write;
    end

    // Automatic memory: answers any request after three cycles when enabled.
    initial forever begin
        @(negedge clk);
        if (auto_en) begin
            if (pm_if.resp) begin
                pm_if.resp = 1'b0;
            end else if (!reset && (pm_if.read || pm_if.write)) begin
                auto_cnt++;
                if (auto_cnt >= 3) begin
                    auto_cnt = 0;
                    pm_if.rdata = {16{16'hA5A5}};
                    pm_if.resp = 1'b1;
                end
            end else begin
                auto_cnt = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(up_if.read && up_if.write)) else $error("illegal up_read with up_write");
            assert (!(pm_if.read && pm_if.write)) else $error("pmem read and write together");
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic start_req(input bit wr, input logic [15:0] addr, input lc3b_c_line d);
        @(negedge clk);
        up_if.address = addr;
        up_if.wdata   = d;
        up_if.write   = wr;
        up_if.read    = !wr;
    endtask

    // n counts falling edges until up_resp is seen; L2 captures it on the next rising edge.
    task automatic wait_resp(input int budget, output bit ok, output int n);
        ok = 1'b0;
        n = 0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            if (up_if.resp === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            $display("up txn addr=%h wr=%0d cycles=%0d rdata[31:0]=%h",
                     up_if.address, up_if.write, n + 1, up_if.rdata[31:0]);
            up_if.read  = 1'b0;
            up_if.write = 1'b0;
        end
    endtask

    task automatic pulse_resp(input lc3b_c_line d);
        @(negedge clk);
        pm_if.rdata = d;
        pm_if.resp  = 1'b1;
        @(posedge clk);
        #1;
        pm_if.resp  = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (dut.w_count == 0 && pm_if.write == 1'b0 && pm_if.read == 1'b0) ok = 1'b1;
        end
    endtask

    task automatic wait_pm_write(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (pm_if.write === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (up_if.resp !== 1'b0) begin bad++; $display("FAIL reset_up_resp got=%b want=0", up_if.resp); end
        total++; if (up_if.rdata !== '0) begin bad++; $display("FAIL reset_up_rdata got=%h want=0", up_if.rdata); end
        total++; if (pm_if.read !== 1'b0 || pm_if.write !== 1'b0) begin bad++; $display("FAIL reset_pmem_rw got=%b%b want=00", pm_if.read, pm_if.write); end
        total++; if (pm_if.address !== 16'h0 || pm_if.wdata !== '0) begin bad++; $display("FAIL reset_pmem_bus addr=%h want=0000", pm_if.address); end
        total++; if (dut.w_count !== 0) begin bad++; $display("FAIL reset_count got=%0d want=0", dut.w_count); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_evict();
        bit ok; int n;
        ops.delete(); auto_cnt = 0; auto_en = 1'b1;
        start_req(1'b1, 16'h1240, mk(32'hAAAA_0001)); wait_resp(10, ok, n);
        total++; if (!ok || n + 1 != 2) begin bad++; $display("FAIL evict_latency got=%0d want=2", ok ? n + 1 : -1); end
        wait_idle(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL evict_drain_done got=timeout want=idle"); end
        #1;
        total++;
        if (ops.size() != 1) begin
            bad++; $display("FAIL evict_op_count got=%0d want=1", ops.size());
        end else if (!ops[0].is_wr || ops[0].addr !== 16'h1240 || ops[0].data !== mk(32'hAAAA_0001)) begin
            bad++; $display("FAIL evict_pmem_write got wr=%0d addr=%h data=%h want wr=1 addr=1240", ops[0].is_wr, ops[0].addr, ops[0].data[31:0]);
        end
        total++; if (dut.w_count !== 0) begin bad++; $display("FAIL evict_count got=%0d want=0", dut.w_count); end
        auto_en = 1'b0;
    endtask

    task automatic test_read_hit();
        bit ok; int n; int reads;
        ops.delete();
        start_req(1'b1, 16'h1240, mk(32'hAAAA_0002)); wait_resp(10, ok, n);
        total++; if (!ok) begin bad++; $display("FAIL hit_write_ack got=timeout want=resp"); end
        repeat (2) @(negedge clk);
        total++; if (pm_if.write !== 1'b1 || pm_if.address !== 16'h1240) begin bad++; $display("FAIL hit_drain_active got wr=%b addr=%h want wr=1 addr=1240", pm_if.write, pm_if.address); end
        start_req(1'b0, 16'h1244, '0); wait_resp(10, ok, n);
        total++; if (!ok || n + 1 != 2) begin bad++; $display("FAIL hit_latency got=%0d want=2", ok ? n + 1 : -1); end
        total++; if (up_if.rdata !== mk(32'hAAAA_0002)) begin bad++; $display("FAIL hit_rdata got=%h want=aaaa0002", up_if.rdata[31:0]); end
        #1;
        reads = 0;
        foreach (ops[i]) if (!ops[i].is_wr) reads++;
        total++; if (reads != 0) begin bad++; $display("FAIL hit_no_pmem_read got=%0d want=0", reads); end
        pulse_resp('0);
        wait_idle(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL hit_drain_done got=timeout want=idle"); end
    endtask

    task automatic test_full_stall();
        bit ok; int n;
        logic [15:0] ea [3];
        lc3b_c_line  ed [3];
        ea[0] = 16'h0020; ea[1] = 16'h0040; ea[2] = 16'h0060;
        ed[0] = mk(32'hC000_0000); ed[1] = mk(32'hC000_0001); ed[2] = mk(32'hC000_0002);
        ops.delete();
        for (int i = 0; i < 2; i++) begin
            start_req(1'b1, ea[i], ed[i]); wait_resp(10, ok, n);
            total++; if (!ok) begin bad++; $display("FAIL full_fill_ack%0d got=timeout want=resp", i); end
        end
        total++; if (dut.w_count !== 2) begin bad++; $display("FAIL full_count got=%0d want=2", dut.w_count); end
        start_req(1'b1, ea[2], ed[2]); wait_resp(6, ok, n);
        total++; if (ok) begin bad++; $display("FAIL full_stall got=resp want=no_resp"); end
        pulse_resp('0);
        wait_resp(8, ok, n);
        total++; if (!ok) begin bad++; $display("FAIL full_resp_after_drain got=timeout want=resp"); end
        total++; if (dut.w_count !== 2) begin bad++; $display("FAIL full_count_after got=%0d want=2", dut.w_count); end
        auto_cnt = 0; auto_en = 1'b1;
        wait_idle(80, ok);
        auto_en = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL full_drain_done got=timeout want=idle"); end
        #1;
        total++;
        if (ops.size() != 3) begin
            bad++; $display("FAIL full_op_count got=%0d want=3", ops.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (!ops[i].is_wr || ops[i].addr !== ea[i] || ops[i].data !== ed[i]) begin
                    bad++; $display("FAIL full_drain_order%0d got addr=%h data=%h want addr=%h data=%h", i, ops[i].addr, ops[i].data[31:0], ea[i], ed[i][31:0]);
                end
            end
        end
    endtask

    task automatic test_coalesce();
        bit ok; int n;
        ops.delete();
        start_req(1'b1, 16'h0100, mk(32'hD000_0000)); wait_resp(10, ok, n);
        start_req(1'b1, 16'h0040, mk(32'hD000_0001)); wait_resp(10, ok, n);
        start_req(1'b0, 16'h0048, '0); wait_resp(10, ok, n);
        total++; if (!ok || up_if.rdata !== mk(32'hD000_0001)) begin bad++; $display("FAIL coal_queued_hit got=%h want=d0000001", up_if.rdata[31:0]); end
        start_req(1'b1, 16'h0040, mk(32'hB000_0004)); wait_resp(10, ok, n);
        total++; if (!ok || n + 1 != 2) begin bad++; $display("FAIL coal_latency got=%0d want=2", ok ? n + 1 : -1); end
        total++; if (dut.w_count !== 2) begin bad++; $display("FAIL coal_count got=%0d want=2", dut.w_count); end
        start_req(1'b1, 16'h0100, mk(32'hD000_0002)); wait_resp(5, ok, n);
        total++; if (ok) begin bad++; $display("FAIL coal_draining_stall got=resp want=no_resp"); end
        pulse_resp('0);
        wait_resp(8, ok, n);
        total++; if (!ok) begin bad++; $display("FAIL coal_draining_accept got=timeout want=resp"); end
        total++; if (pm_if.write !== 1'b1 || pm_if.address !== 16'h0040 || pm_if.wdata !== mk(32'hB000_0004)) begin
            bad++; $display("FAIL coal_drain_data got wr=%b addr=%h data=%h want wr=1 addr=0040 data=b0000004", pm_if.write, pm_if.address, pm_if.wdata[31:0]);
        end
        pulse_resp('0);
        wait_pm_write(10, ok);
        total++; if (!ok || pm_if.address !== 16'h0100 || pm_if.wdata !== mk(32'hD000_0002)) begin
            bad++; $display("FAIL coal_second_drain got addr=%h data=%h want addr=0100 data=d0000002", pm_if.address, pm_if.wdata[31:0]);
        end
        pulse_resp('0);
        wait_idle(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL coal_drain_done got=timeout want=idle"); end
    endtask

    task automatic test_read_miss();
        bit ok; int n;
        ops.delete();
        start_req(1'b1, 16'h0200, mk(32'hE000_0000)); wait_resp(10, ok, n);
        start_req(1'b1, 16'h0220, mk(32'hE000_0001)); wait_resp(10, ok, n);
        start_req(1'b0, 16'h8000, '0);
        repeat (3) @(negedge clk);
        total++; if (pm_if.read !== 1'b0) begin bad++; $display("FAIL miss_waits_for_drain got=%b want=0", pm_if.read); end
        ops.delete();
        pulse_resp('0);
        ok = 1'b0;
        for (int i = 0; i < 6 && !ok; i++) begin
            @(negedge clk);
            if (pm_if.read === 1'b1) ok = 1'b1;
        end
        #1;
        total++; if (!ok || pm_if.address !== 16'h8000 || pm_if.write !== 1'b0) begin
            bad++; $display("FAIL miss_read_issue got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=8000", pm_if.read, pm_if.write, pm_if.address);
        end
        total++; if (ops.size() < 1 || ops[0].is_wr) begin bad++; $display("FAIL miss_priority got ops=%0d want first=read", ops.size()); end
        pulse_resp(mk(32'h1234_5678));
        wait_resp(4, ok, n);
        total++; if (!ok || up_if.rdata !== mk(32'h1234_5678)) begin bad++; $display("FAIL miss_rdata got=%h want=12345678", up_if.rdata[31:0]); end
        wait_pm_write(10, ok);
        total++; if (!ok || pm_if.address !== 16'h0220) begin bad++; $display("FAIL miss_drain_resume got addr=%h want=0220", pm_if.address); end
        auto_cnt = 0; auto_en = 1'b1;
        wait_idle(40, ok);
        auto_en = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL miss_drain_done got=timeout want=idle"); end
    endtask

    task automatic test_reset_mid();
        bit ok; int n;
        ops.delete();
        start_req(1'b1, 16'h0300, mk(32'hF000_0000)); wait_resp(10, ok, n);
        start_req(1'b1, 16'h0320, mk(32'hF000_0001)); wait_resp(10, ok, n);
        total++; if (!ok || pm_if.write !== 1'b1) begin bad++; $display("FAIL rst_precondition got resp=%0d wr=%b want resp=1 wr=1", ok, pm_if.write); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (pm_if.write !== 1'b0 || pm_if.address !== 16'h0 || pm_if.wdata !== '0) begin
            bad++; $display("FAIL rst_async_pmem got wr=%b addr=%h want wr=0 addr=0000", pm_if.write, pm_if.address);
        end
        total++; if (up_if.resp !== 1'b0) begin bad++; $display("FAIL rst_async_resp got=%b want=0", up_if.resp); end
        total++; if (dut.w_count !== 0) begin bad++; $display("FAIL rst_async_count got=%0d want=0", dut.w_count); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ops.delete();
        repeat (10) @(negedge clk);
        #1;
        total++; if (ops.size() != 0 || pm_if.read !== 1'b0 || pm_if.write !== 1'b0) begin
            bad++; $display("FAIL rst_no_activity got ops=%0d want=0", ops.size());
        end
    endtask

    initial begin
        up_if.address = '0;
        up_if.read    = 1'b0;
        up_if.write   = 1'b0;
        up_if.wdata   = '0;
        pm_if.rdata   = '0;
        pm_if.resp    = 1'b0;
        test_reset();
        test_evict();
        test_read_hit();
        test_full_stall();
        test_coalesce();
        test_read_miss();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
